bounce_sprite: RTL and testbench
================================

// Module: bounce_sprite
// PURPOSE
//   Per-pixel colour source that sits downstream of the VGA timing generator, beside the DRAW stage.
//   Consumes the pixel coordinates and v_sync, and moves a solid rectangle one step per frame,
//   bouncing off the screen edges. Drives 4-bit R/G/B for the current pixel with fixed 2-cycle latency.
// PARAMETERS
//   X_BIT_SIZE  10       width of x coordinate
//   Y_BIT_SIZE  9        width of y coordinate
//   H_ACTIVE    640      visible pixels per line
//   V_ACTIVE    480      visible lines per frame
//   SPRITE_W    32       sprite width, pixels
//   SPRITE_H    32       sprite height, lines
//   STEP        2        pixels moved per frame on each axis (must be < SPRITE_W, SPRITE_H)
//   FG_COLOR    12'hF80  sprite colour {R,G,B}
//   BG_COLOR    12'h000  background colour inside the active area
// PORTS
//   clk       in   1           pixel-domain clock, the same clock VGA_DISPLAY uses
//   reset     in   1           synchronous, active-high
//   run       in   1           1: sprite moves each frame; 0: position frozen
//   x         in   X_BIT_SIZE  current pixel column from the timing generator
//   y         in   Y_BIT_SIZE  current pixel row from the timing generator
//   v_sync    in   1           vertical sync, active-low
//   R, G, B   out  4 each      pixel colour, valid 2 clk after matching x/y
//   sprite_x  out  X_BIT_SIZE  current left edge of the sprite
//   sprite_y  out  Y_BIT_SIZE  current top edge of the sprite
//   bounce    out  1           one-cycle pulse when any axis reverses
// BEHAVIOUR
//   Reset values: R=G=B=0, bounce=0, v_sync_q=1.
//     sprite_x=(H_ACTIVE-SPRITE_W)/2 (304), sprite_y=(V_ACTIVE-SPRITE_H)/2 (224).
//     Direction is +x, +y. Palette index is 0.
//   frame_tick: asserts one cycle on the v_sync falling edge (v_sync_q=1, v_sync=0). v_sync_q is registered.
//   Motion FSM: FROZEN / MOVING. FROZEN->MOVING when run=1 is sampled at a frame_tick.
//     MOVING->FROZEN when run=0 is sampled at a frame_tick.
//     Position updates only at a frame_tick in MOVING, so it never changes mid-frame (no tearing).
//   Axis update, per axis, computed one bit wider than the coordinate (no wrap):
//     +dir: n=pos+STEP; if n+SIZE >= LIMIT then pos=LIMIT-SIZE and dir flips to -, else pos=n.
//     -dir: if pos <= STEP then pos=0 and dir flips to +, else pos=pos-STEP.
//   Simultaneous x and y flips (corner): both flip in the same tick. bounce pulses once; palette advances once.
//   bounce asserts in the cycle after the frame_tick that caused the flip.
//   Pixel pipe:
//     stage1 registers hit = (x in [sprite_x, sprite_x+SPRITE_W)) && (y in [sprite_y, sprite_y+SPRITE_H)),
//     plus active = (x < H_ACTIVE && y < V_ACTIVE).
//     stage2 registers RGB = !active ? 0 : hit ? fg : BG_COLOR.
//   Reset mid-frame: all state returns to reset values the next cycle. The pipe outputs 0 for 2 cycles.
// CONFIGURATION
//   BOUNCE_SPRITE_PALETTE_EN defined:
//     fg = palette[idx], where palette = {FG_COLOR, 12'h0F0, 12'h00F, 12'hFF0}.
//     idx (2 bits) increments on every bounce and wraps 3->0.
//   Not defined: fg = FG_COLOR. No palette logic. bounce is still generated.
// STRUCTURE
//   Shared package vga_pkg holds:
//     - H_ACTIVE and V_ACTIVE defaults
//     - typedef rgb12_t {4'R, 4'G, 4'B}
//     - typedef dir_t (POS/NEG)
//     - motion state enum {FROZEN, MOVING}
//   Sub-module sprite_axis: one instance per axis, parameterised by LIMIT/SIZE/width.
//     Holds pos and dir; outputs a flip pulse. The top combines the flip pulses into bounce.
// TESTING
//   1 Reset, then hold run=0 for 3 frames.
//     -> sprite_x=304, sprite_y=224, bounce never asserts; RGB is 0 while reset is asserted.
//   2 run=1, 1 frame.
//     -> sprite_x=306, sprite_y=226 after the tick; unchanged until the next v_sync falling edge.
//   3 Drive x=306,y=226 then x=305,y=226 on consecutive clocks.
//     -> RGB=F,8,0 then 0,0,0 at 2-cycle latency; x=700 -> RGB=0 (outside the active area).
//   4 Run until sprite_x reaches 608.
//     -> sprite_x clamps at 608, x dir flips, bounce pulses exactly 1 cycle, next frame x=606.
//   5 Force the corner (preload via reset + frames to reach x=0, y=0).
//     -> both axes flip in the same tick; one bounce pulse; with BOUNCE_SPRITE_PALETTE_EN, idx+1 only.
//   6 Assert reset on the frame_tick cycle while MOVING.
//     -> next cycle position=(304,224), direction=+,+, state FROZEN, idx=0, no bounce.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA-side types and defaults used by the sprite generator and its axis sub-module.
// Holds screen defaults, the 12-bit colour struct, direction and motion-state enums, and the palette lookup.
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef enum logic {
    FROZEN = 1'b0,
    MOVING = 1'b1
  } motion_state_t;

  localparam logic [11:0] PALETTE_1 = 12'h0F0;
  localparam logic [11:0] PALETTE_2 = 12'h00F;
  localparam logic [11:0] PALETTE_3 = 12'hFF0;

  // Entry 0 is the configured sprite colour so a fresh reset always shows it.
  function automatic rgb12_t palette_color(input logic [1:0] idx, input rgb12_t base);
    rgb12_t c;
    case (idx)
      2'd0:    c = base;
      2'd1:    c = rgb12_t'(PALETTE_1);
      2'd2:    c = rgb12_t'(PALETTE_2);
      default: c = rgb12_t'(PALETTE_3);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bounce_sprite_if.sv
// Pixel-side bus of bounce_sprite: timing-generator inputs in, colour and sprite status out.
// The master modport belongs to whatever drives coordinates; the slave modport is the sprite block.
interface bounce_sprite_if #(
  parameter int X_BIT_SIZE = 10,
  parameter int Y_BIT_SIZE = 9
);

  logic                  run;
  logic [X_BIT_SIZE-1:0] x;
  logic [Y_BIT_SIZE-1:0] y;
  logic                  v_sync;
  logic [3:0]            R;
  logic [3:0]            G;
  logic [3:0]            B;
  logic [X_BIT_SIZE-1:0] sprite_x;
  logic [Y_BIT_SIZE-1:0] sprite_y;
  logic                  bounce;

  modport master (
    output run, x, y, v_sync,
    input  R, G, B, sprite_x, sprite_y, bounce
  );

  modport slave (
    input  run, x, y, v_sync,
    output R, G, B, sprite_x, sprite_y, bounce
  );

endinterface

// File: rtl/bounce_sprite_axis.sv
// One motion axis of the bouncing sprite: position, direction and a registered flip pulse.
// Arithmetic is one bit wider than the coordinate so the edge test can never wrap.
module sprite_axis
  import vga_pkg::*;
#(
  parameter int W     = 10,
  parameter int LIMIT = 640,
  parameter int SIZE  = 32,
  parameter int STEP  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         update,
  output logic [W-1:0] pos,
  output logic         flip
);

  localparam int          RESET_INT = (LIMIT - SIZE) / 2;
  localparam int          MAX_INT   = LIMIT - SIZE;
  localparam logic [W-1:0] RESET_POS = RESET_INT[W-1:0];
  localparam logic [W-1:0] MAX_POS   = MAX_INT[W-1:0];
  localparam logic [W:0]   LIMIT_W   = LIMIT[W:0];
  localparam logic [W:0]   SIZE_W    = SIZE[W:0];
  localparam logic [W:0]   STEP_W    = STEP[W:0];

  logic [W-1:0] pos_q, pos_d;
  dir_t         dir_q, dir_d;
  logic         flip_q, flip_d;
  logic [W:0]   pos_wide;
  logic [W:0]   next_wide;
  logic [W:0]   far_edge;

  always_comb begin
    pos_d     = pos_q;
    dir_d     = dir_q;
    flip_d    = 1'b0;
    pos_wide  = {1'b0, pos_q};
    next_wide = pos_wide + STEP_W;
    far_edge  = next_wide + SIZE_W;
    if (update) begin
      if (dir_q == DIR_POS) begin
        // Clamp exactly against the far edge instead of overshooting by part of a step.
        if (far_edge >= LIMIT_W) begin
          pos_d  = MAX_POS;
          dir_d  = DIR_NEG;
          flip_d = 1'b1;
        end else begin
          pos_d = next_wide[W-1:0];
        end
      end else begin
        if (pos_wide <= STEP_W) begin
          pos_d  = '0;
          dir_d  = DIR_POS;
          flip_d = 1'b1;
        end else begin
          pos_d = pos_q - STEP_W[W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q  <= RESET_POS;
      dir_q  <= DIR_POS;
      flip_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      flip_q <= flip_d;
    end
  end

  assign pos  = pos_q;
  assign flip = flip_q;

endmodule

// File: rtl/bounce_sprite.sv
// Per-pixel colour source drawing a solid rectangle that bounces off the screen edges once per frame.
// Define BOUNCE_SPRITE_PALETTE_EN to cycle the sprite colour through a 4-entry palette on every bounce.
module bounce_sprite
  import vga_pkg::*;
#(
  parameter int          X_BIT_SIZE = 10,
  parameter int          Y_BIT_SIZE = 9,
  parameter int          H_ACTIVE   = H_ACTIVE_DEFAULT,
  parameter int          V_ACTIVE   = V_ACTIVE_DEFAULT,
  parameter int          SPRITE_W   = 32,
  parameter int          SPRITE_H   = 32,
  parameter int          STEP       = 2,
  parameter logic [11:0] FG_COLOR   = 12'hF80,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic           clk,
  input  logic           reset,
  bounce_sprite_if.slave bus
);

  localparam logic [X_BIT_SIZE:0] H_LIM      = H_ACTIVE[X_BIT_SIZE:0];
  localparam logic [Y_BIT_SIZE:0] V_LIM      = V_ACTIVE[Y_BIT_SIZE:0];
  localparam logic [X_BIT_SIZE:0] SPRITE_W_X = SPRITE_W[X_BIT_SIZE:0];
  localparam logic [Y_BIT_SIZE:0] SPRITE_H_Y = SPRITE_H[Y_BIT_SIZE:0];

  logic          v_sync_q, v_sync_d;
  motion_state_t state_q, state_d;
  logic          frame_tick;
  logic          update;

  logic [X_BIT_SIZE-1:0] x_pos;
  logic [Y_BIT_SIZE-1:0] y_pos;
  logic                  x_flip;
  logic                  y_flip;
  logic                  bounce;

  // Frame tick is the falling edge of the active-low vertical sync.
  always_comb begin
    v_sync_d   = bus.v_sync;
    frame_tick = v_sync_q & ~bus.v_sync;
  end

  always_comb begin
    state_d = state_q;
    update  = 1'b0;
    if (frame_tick) begin
      update  = (state_q == MOVING);
      state_d = bus.run ? MOVING : FROZEN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_sync_q <= 1'b1;
      state_q  <= FROZEN;
    end else begin
      v_sync_q <= v_sync_d;
      state_q  <= state_d;
    end
  end

  sprite_axis #(
    .W     (X_BIT_SIZE),
    .LIMIT (H_ACTIVE),
    .SIZE  (SPRITE_W),
    .STEP  (STEP)
  ) u_axis_x (
    .clk    (clk),
    .reset  (reset),
    .update (update),
    .pos    (x_pos),
    .flip   (x_flip)
  );

  sprite_axis #(
    .W     (Y_BIT_SIZE),
    .LIMIT (V_ACTIVE),
    .SIZE  (SPRITE_H),
    .STEP  (STEP)
  ) u_axis_y (
    .clk    (clk),
    .reset  (reset),
    .update (update),
    .pos    (y_pos),
    .flip   (y_flip)
  );

  // A corner flips both axes in one tick but still counts as a single bounce.
  assign bounce = x_flip | y_flip;

  rgb12_t fg;

`ifdef BOUNCE_SPRITE_PALETTE_EN
  logic [1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (bounce) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= 2'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign fg = palette_color(idx_q, rgb12_t'(FG_COLOR));
`else
  assign fg = rgb12_t'(FG_COLOR);
`endif

  logic                  hit_q, hit_d;
  logic                  active_q, active_d;
  rgb12_t                rgb_q, rgb_d;
  logic [X_BIT_SIZE:0]   x_wide;
  logic [Y_BIT_SIZE:0]   y_wide;
  logic [X_BIT_SIZE:0]   x_end;
  logic [Y_BIT_SIZE:0]   y_end;

  always_comb begin
    x_wide   = {1'b0, bus.x};
    y_wide   = {1'b0, bus.y};
    x_end    = {1'b0, x_pos} + SPRITE_W_X;
    y_end    = {1'b0, y_pos} + SPRITE_H_Y;
    hit_d    = (x_wide >= {1'b0, x_pos}) && (x_wide < x_end) &&
               (y_wide >= {1'b0, y_pos}) && (y_wide < y_end);
    active_d = (x_wide < H_LIM) && (y_wide < V_LIM);
  end

  always_comb begin
    rgb_d = '0;
    if (active_q) begin
      rgb_d = hit_q ? fg : rgb12_t'(BG_COLOR);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q    <= 1'b0;
      active_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hit_q    <= hit_d;
      active_q <= active_d;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.R        = rgb_q.r;
  assign bus.G        = rgb_q.g;
  assign bus.B        = rgb_q.b;
  assign bus.sprite_x = x_pos;
  assign bus.sprite_y = y_pos;
  assign bus.bounce   = bounce;

endmodule

// File: tb/tb_bounce_sprite.sv
// Directed bench for bounce_sprite: a 640x480 instance plus a small square instance that reaches corners.
// Pixel results are scoreboarded with their 2-cycle due time; honours BOUNCE_SPRITE_PALETTE_EN.
`timescale 1ns/1ps
module tb_bounce_sprite;

  localparam int FRAME_GAP = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bounce_sprite_if #(.X_BIT_SIZE(10), .Y_BIT_SIZE(9)) bus  ();
  bounce_sprite_if #(.X_BIT_SIZE(10), .Y_BIT_SIZE(9)) bus2 ();

  bounce_sprite dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  bounce_sprite #(
    .H_ACTIVE (64),
    .V_ACTIVE (64),
    .SPRITE_W (16),
    .SPRITE_H (16),
    .BG_COLOR (12'h123)
  ) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  typedef struct {
    int          due;
    int          sel;
    logic [11:0] rgb;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  bcnt     = 0;
  int  bcnt2    = 0;

  int m_x, m_y, m_bounces, m_idx;
  bit m_xneg, m_yneg, m_moving;
  int s_x, s_y, s_bounces, s_idx;
  bit s_xneg, s_yneg, s_moving;

  always @(negedge clk) begin
    if (bus.bounce === 1'b1)  bcnt  <= bcnt + 1;
    if (bus2.bounce === 1'b1) bcnt2 <= bcnt2 + 1;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [11:0] exp_fg(input int idx);
`ifdef BOUNCE_SPRITE_PALETTE_EN
    logic [11:0] pal [4];
    pal[0] = 12'hF80;
    pal[1] = 12'h0F0;
    pal[2] = 12'h00F;
    pal[3] = 12'hFF0;
    return pal[idx % 4];
`else
    return (idx >= 0) ? 12'hF80 : 12'hF80;
`endif
  endfunction

  function automatic void axis_model(input int pos, input bit neg, input int limit, input int size,
                                     output int npos, output bit nneg, output bit flip);
    npos = pos;
    nneg = neg;
    flip = 1'b0;
    if (!neg) begin
      if (pos + 2 + size >= limit) begin
        npos = limit - size;
        nneg = 1'b1;
        flip = 1'b1;
      end else begin
        npos = pos + 2;
      end
    end else begin
      if (pos <= 2) begin
        npos = 0;
        nneg = 1'b0;
        flip = 1'b1;
      end else begin
        npos = pos - 2;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick_cycle();
    sb_t e;
    logic [11:0] got;
    @(negedge clk);
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      got = (e.sel == 0) ? {bus.R, bus.G, bus.B} : {bus2.R, bus2.G, bus2.B};
      checkOutput(e.tag, {20'd0, got}, {20'd0, e.rgb});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic applyStimulus(input int sel, input int px, input int py, input logic [11:0] rgb, input string tag);
    sb_t e;
    if (sel == 0) begin
      bus.x = 10'(px);
      bus.y = 9'(py);
    end else begin
      bus2.x = 10'(px);
      bus2.y = 9'(py);
    end
    e.due = cyc + 2;
    e.sel = sel;
    e.rgb = rgb;
    e.tag = tag;
    sb.push_back(e);
    tick_cycle();
  endtask

  task automatic model_reset();
    m_x = 304; m_y = 224; m_xneg = 0; m_yneg = 0; m_moving = 0; m_bounces = 0; m_idx = 0;
    s_x = 24;  s_y = 24;  s_xneg = 0; s_yneg = 0; s_moving = 0; s_bounces = 0; s_idx = 0;
  endtask

  // Leaves the bench at the first sample point after the tick edge.
  task automatic frame_tick_drive();
    int nx, ny;
    bit fx, fy;
    bus.v_sync  = 1'b0;
    bus2.v_sync = 1'b0;
    tick_cycle();
    bus.v_sync  = 1'b1;
    bus2.v_sync = 1'b1;
    if (m_moving) begin
      axis_model(m_x, m_xneg, 640, 32, nx, m_xneg, fx);
      axis_model(m_y, m_yneg, 480, 32, ny, m_yneg, fy);
      m_x = nx; m_y = ny;
      if (fx || fy) begin m_bounces++; m_idx++; end
    end
    m_moving = bus.run;
    if (s_moving) begin
      axis_model(s_x, s_xneg, 64, 16, nx, s_xneg, fx);
      axis_model(s_y, s_yneg, 64, 16, ny, s_yneg, fy);
      s_x = nx; s_y = ny;
      if (fx || fy) begin s_bounces++; s_idx++; end
    end
    s_moving = bus2.run;
  endtask

  task automatic do_frame();
    frame_tick_drive();
    idle(FRAME_GAP);
  endtask

  initial begin
    reset       = 1'b1;
    bus.run     = 1'b0;
    bus.v_sync  = 1'b1;
    bus.x       = 10'd310;
    bus.y       = 9'd230;
    bus2.run    = 1'b0;
    bus2.v_sync = 1'b1;
    bus2.x      = 10'd30;
    bus2.y      = 9'd30;
    model_reset();

    $display("[TB] reset and frozen frames");
    idle(3);
    checkOutput("rgb_in_reset", {20'd0, bus.R, bus.G, bus.B}, 32'd0);
    checkOutput("rgb2_in_reset", {20'd0, bus2.R, bus2.G, bus2.B}, 32'd0);
    checkOutput("reset_x", {22'd0, bus.sprite_x}, 32'd304);
    checkOutput("reset_y", {23'd0, bus.sprite_y}, 32'd224);
    checkOutput("reset_bounce", {31'd0, bus.bounce}, 32'd0);
    checkOutput("reset_small_x", {22'd0, bus2.sprite_x}, 32'd24);
    reset = 1'b0;
    applyStimulus(0, 310, 230, 12'hF80, "post_reset_hit");
    applyStimulus(1, 30, 30, 12'hF80, "post_reset_hit_small");
    idle(2);
    for (int f = 0; f < 3; f++) begin
      do_frame();
      checkOutput("frozen_x", {22'd0, bus.sprite_x}, 32'd304);
      checkOutput("frozen_y", {23'd0, bus.sprite_y}, 32'd224);
    end
    checkOutput("frozen_no_bounce", bcnt, 32'd0);

    $display("[TB] start moving");
    bus.run = 1'b1;
    do_frame();
    checkOutput("enter_moving_x", {22'd0, bus.sprite_x}, 32'd304);
    frame_tick_drive();
    checkOutput("first_step_x", {22'd0, bus.sprite_x}, 32'd306);
    checkOutput("first_step_y", {23'd0, bus.sprite_y}, 32'd226);
    idle(FRAME_GAP);
    checkOutput("midframe_x", {22'd0, bus.sprite_x}, 32'd306);
    checkOutput("midframe_y", {23'd0, bus.sprite_y}, 32'd226);

    $display("[TB] pixel pipe");
    applyStimulus(0, 306, 226, 12'hF80, "pix_corner_in");
    applyStimulus(0, 305, 226, 12'h000, "pix_left_out");
    applyStimulus(0, 700, 226, 12'h000, "pix_inactive");
    applyStimulus(0, 337, 257, 12'hF80, "pix_far_in");
    applyStimulus(0, 306, 258, 12'h000, "pix_below_out");
    idle(2);

    $display("[TB] run to right edge");
    for (int g = 0; g < 400 && m_x != 606; g++) begin
      do_frame();
      checkOutput("track_x", {22'd0, bus.sprite_x}, m_x);
      checkOutput("track_y", {23'd0, bus.sprite_y}, m_y);
    end
    checkOutput("pre_edge_x", {22'd0, bus.sprite_x}, 32'd606);
    checkOutput("pre_edge_y", {23'd0, bus.sprite_y}, 32'd370);
    checkOutput("y_bounce_count", bcnt, 32'd1);
    frame_tick_drive();
    checkOutput("clamp_x", {22'd0, bus.sprite_x}, 32'd608);
    checkOutput("clamp_y", {23'd0, bus.sprite_y}, 32'd368);
    checkOutput("bounce_high", {31'd0, bus.bounce}, 32'd1);
    tick_cycle();
    checkOutput("bounce_low", {31'd0, bus.bounce}, 32'd0);
    idle(FRAME_GAP);
    checkOutput("edge_bounce_count", bcnt, m_bounces);
    do_frame();
    checkOutput("return_x", {22'd0, bus.sprite_x}, 32'd606);
    checkOutput("return_y", {23'd0, bus.sprite_y}, 32'd366);
    applyStimulus(0, 606, 366, exp_fg(m_idx), "pix_after_bounce");
    applyStimulus(0, 637, 397, exp_fg(m_idx), "pix_after_bounce_far");
    applyStimulus(0, 638, 366, 12'h000, "pix_after_bounce_out");
    idle(2);

    $display("[TB] small instance corners");
    bus2.run = 1'b1;
    do_frame();
    checkOutput("small_enter_x", {22'd0, bus2.sprite_x}, 32'd24);
    for (int f = 0; f < 11; f++) begin
      do_frame();
      checkOutput("small_track_x", {22'd0, bus2.sprite_x}, s_x);
      checkOutput("small_track_y", {23'd0, bus2.sprite_y}, s_y);
    end
    frame_tick_drive();
    checkOutput("corner_far_x", {22'd0, bus2.sprite_x}, 32'd48);
    checkOutput("corner_far_y", {23'd0, bus2.sprite_y}, 32'd48);
    checkOutput("corner_far_bounce", {31'd0, bus2.bounce}, 32'd1);
    tick_cycle();
    checkOutput("corner_far_bounce_low", {31'd0, bus2.bounce}, 32'd0);
    idle(FRAME_GAP);
    checkOutput("corner_far_count", bcnt2, 32'd1);
    for (int f = 0; f < 23; f++) do_frame();
    checkOutput("pre_origin_x", {22'd0, bus2.sprite_x}, 32'd2);
    frame_tick_drive();
    checkOutput("origin_x", {22'd0, bus2.sprite_x}, 32'd0);
    checkOutput("origin_y", {23'd0, bus2.sprite_y}, 32'd0);
    checkOutput("origin_bounce", {31'd0, bus2.bounce}, 32'd1);
    tick_cycle();
    checkOutput("origin_bounce_low", {31'd0, bus2.bounce}, 32'd0);
    idle(FRAME_GAP);
    checkOutput("origin_count", bcnt2, 32'd2);
    applyStimulus(1, 0, 0, exp_fg(2), "small_pix_origin");
    applyStimulus(1, 15, 15, exp_fg(2), "small_pix_inner");
    applyStimulus(1, 16, 0, 12'h123, "small_pix_bg");
    applyStimulus(1, 70, 0, 12'h000, "small_pix_off_x");
    applyStimulus(1, 0, 70, 12'h000, "small_pix_off_y");
    idle(2);

    $display("[TB] reset on frame tick");
    checkOutput("pre_reset_moved", {31'd0, (bus.sprite_x != 10'd304)}, 32'd1);
    bus.v_sync  = 1'b0;
    bus2.v_sync = 1'b0;
    reset       = 1'b1;
    tick_cycle();
    bus.v_sync  = 1'b1;
    bus2.v_sync = 1'b1;
    model_reset();
    checkOutput("tick_reset_x", {22'd0, bus.sprite_x}, 32'd304);
    checkOutput("tick_reset_y", {23'd0, bus.sprite_y}, 32'd224);
    checkOutput("tick_reset_bounce", {31'd0, bus.bounce}, 32'd0);
    checkOutput("tick_reset_small_x", {22'd0, bus2.sprite_x}, 32'd24);
    reset = 1'b0;
    idle(2);
    do_frame();
    checkOutput("after_reset_frozen_x", {22'd0, bus.sprite_x}, 32'd304);
    do_frame();
    checkOutput("after_reset_dir_x", {22'd0, bus.sprite_x}, 32'd306);
    checkOutput("after_reset_dir_y", {23'd0, bus.sprite_y}, 32'd226);
    applyStimulus(0, 306, 226, 12'hF80, "pix_palette_reset");
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
